// File: rtl/dff_mux.sv
// dff_mux: positive-edge DFF built as a master-slave pair of 2:1-mux latches, with q/qb outputs.
// Optional clock enable (input ce) when DFF_MUX_CE_EN is defined.

module dff_mux_mux2 #(
   parameter int FB = 0  // 0: plain mux, 1: out fed back to b, 2: out fed back to a
) (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic out
);
   generate
      if (FB == 1) begin : g_fb_b
         // Loop is closed here so the hold path reads as a level-sensitive latch
         logic w_unused_b;
         assign w_unused_b = b;
         always_latch if (!sel) out <= a;
      end else if (FB == 2) begin : g_fb_a
         logic w_unused_a;
         assign w_unused_a = a;
         always_latch if (sel) out <= b;
      end else begin : g_comb
         assign out = sel ? b : a;
      end
   endgenerate
endmodule

module dff_mux #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
`ifdef DFF_MUX_CE_EN
   input  logic             ce,
`endif
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);
   logic [WIDTH-1:0] w_d_sel;
   logic [WIDTH-1:0] w_d_int;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef DFF_MUX_CE_EN
      dff_mux_mux2 #(.FB(0)) u_ce (.a(r_s[i]), .b(d[i]), .sel(ce), .out(w_d_sel[i]));
`else
      assign w_d_sel[i] = d[i];
`endif
      // Reset rides the data path, so it only lands at a rising edge
      dff_mux_mux2 #(.FB(0)) u_rst (.a(w_d_sel[i]), .b(1'b0),    .sel(rst), .out(w_d_int[i]));
      dff_mux_mux2 #(.FB(1)) u_mst (.a(w_d_int[i]), .b(r_m[i]),  .sel(clk), .out(r_m[i]));
      dff_mux_mux2 #(.FB(2)) u_slv (.a(r_s[i]),     .b(r_m[i]),  .sel(clk), .out(r_s[i]));
   end

   assign q  = r_s;
   assign qb = ~r_s;
endmodule

// File: tb/tb_dff_mux.sv
// Self-checking bench for dff_mux (WIDTH=8); covers the clock-enable port when DFF_MUX_CE_EN is defined.

module tb_dff_mux;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ce  = 1'b1;
   logic [W-1:0] d   = '0;
   logic [W-1:0] q, qb;
   logic [W-1:0] m_q = '0;
   int           errors = 0;
   int           checks = 0;

   always #10 clk = ~clk;

   dff_mux #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
`ifdef DFF_MUX_CE_EN
      .ce(ce),
`endif
      .d(d),
      .q(q),
      .qb(qb)
   );

   // Reference: at each rising edge, q <= reset ? 0 : (enabled ? d : q)
   task automatic step();
      @(posedge clk);
      m_q = rst ? '0 : (ce ? d : m_q);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; d = 8'hFF;
      step();
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h want=00", q); end
      checks++; if (qb !== 8'hFF) begin errors++; $display("FAIL reset_qb got=%h want=ff", qb); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sequence();
      logic [6:0] seq;
      seq = 7'b1011010;  // bit0 first: 0,1,0,1,1,0,1
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         d = seq[i] ? '1 : '0;
         step();
         checks++;
         if (q !== (seq[i] ? 8'hFF : 8'h00) || qb !== (seq[i] ? 8'h00 : 8'hFF)) begin
            errors++; $display("FAIL seq[%0d] q=%h qb=%h want_bit=%b", i, q, qb, seq[i]);
         end
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      d = '0;
      step();
      #2 d = '1;
      #2 d = '0;
      #2;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL glitch_hold got=%h want=00", q); end
      @(negedge clk);
      d = '1;
      step();
      checks++; if (q !== 8'hFF || qb !== 8'h00) begin errors++; $display("FAIL glitch_load q=%h qb=%h want=ff/00", q, qb); end
   endtask

   task automatic test_sync_reset();
      @(negedge clk);
      #5 rst = 1'b1;
      #2;
      checks++; if (q !== 8'hFF) begin errors++; $display("FAIL rst_midlow got=%h want=ff", q); end
      step();
      checks++; if (q !== 8'h00 || qb !== 8'hFF) begin errors++; $display("FAIL rst_edge q=%h qb=%h want=00/ff", q, qb); end
      step();  // rst=1 and d=1 together: reset wins
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_prio got=%h want=00", q); end
   endtask

   task automatic test_reset_release();
      #3 rst = 1'b0;  // mid high phase
      #3;
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL release_mid got=%h want=00", q); end
      step();
      checks++; if (q !== 8'hFF) begin errors++; $display("FAIL release_edge got=%h want=ff", q); end
   endtask

   task automatic test_width();
      @(negedge clk);
      d = 8'hA5;
      step();
      checks++; if (q !== 8'hA5 || qb !== 8'h5A) begin errors++; $display("FAIL width_a5 q=%h qb=%h want=a5/5a", q, qb); end
      @(negedge clk);
      d = 8'h3C;
      step();
      checks++; if (q !== 8'h3C || qb !== 8'hC3) begin errors++; $display("FAIL width_3c q=%h qb=%h want=3c/c3", q, qb); end
   endtask

`ifdef DFF_MUX_CE_EN
   task automatic test_ce();
      @(negedge clk);
      ce = 1'b1; d = '1;
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ce = 1'b0; d = '0;
         step();
         checks++; if (q !== 8'hFF) begin errors++; $display("FAIL ce_hold[%0d] got=%h want=ff", i, q); end
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL ce_rst got=%h want=00", q); end
      @(negedge clk);
      rst = 1'b0; ce = 1'b1;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         d   = W'($urandom);
         rst = ($urandom_range(0, 7) == 0);
`ifdef DFF_MUX_CE_EN
         ce  = ($urandom_range(0, 3) != 0);
`endif
         step();
         checks++;
         if (q !== m_q || qb !== ~m_q) begin
            errors++; $display("FAIL rand[%0d] q=%h qb=%h want=%h", i, q, qb, m_q);
         end
         #3 d = W'($urandom);  // high-phase change must not leak through
         #3;
         checks++;
         if (q !== m_q) begin errors++; $display("FAIL rand_hi[%0d] q=%h want=%h", i, q, m_q); end
      end
      @(negedge clk);
      rst = 1'b0; ce = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_glitch();
      test_sync_reset();
      test_reset_release();
      test_width();
`ifdef DFF_MUX_CE_EN
      test_ce();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dff_mux.md
Name: dff_mux

Overview:
- Positive-edge-triggered D flip-flop built structurally as a master-slave pair of 2:1-multiplexer latches, with a complementary output.
- Serves as the library reference register cell for mux-based sequential logic; instantiated wherever a gate-level-style DFF with true and complement outputs is needed.
- Vector-capable: WIDTH independent bit slices share one clock and reset.

Parameters:
- WIDTH, 1, number of independent flip-flop bit slices.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data.
- qb  output  WIDTH  complement of q.

Behaviour:
- Per bit, internal 2:1 mux primitive (submodule dff_mux_mux2: inputs a, b, sel; out = sel ? b : a). All storage is formed from these muxes with feedback. No behavioural always @(posedge) register for the state.
- Reset gating mux: d_int = rst ? 0 : d. Implemented with a dff_mux_mux2, so reset is applied through the data path and is therefore synchronous.
- Master latch: m = clk ? m : d_int. It is transparent while clk=0 and holds while clk=1.
- Slave latch: s = clk ? m : s. It is transparent while clk=1 and holds while clk=0.
- q = s; qb = ~s. qb is the bitwise inverse of q at all times once q is defined.
- Net effect: q takes the value of d (or 0 if rst=1) present just before each rising clk edge. Latency is one edge, with no further delay.
- d changes while clk=1 do not affect q until the next rising edge. d changes while clk=0 are captured only at the rising edge.
- Reset: rst=1 sampled at a rising edge gives q=0 and qb=all-ones after that edge. rst asserted between edges has no effect until the next rising edge. Deasserting rst mid-cycle also takes effect only at the next rising edge.
- Power-up: q and qb are undefined (X in simulation) until the first rising edge with rst=1 or with a known d. No initial blocks.
- Simultaneous rst=1 and any d at an edge: reset wins, so q=0.
- Bits are fully independent. There is no cross-bit logic.
- Pure combinational feedback loops are intentional. Lint waivers for latch inference apply only inside dff_mux_mux2 feedback paths.

Optional Feature:
- Macro DFF_MUX_CE_EN.
  - When defined: adds input port ce (1 bit, after rst). A third dff_mux2 per bit selects d_ce = ce ? d : q before the reset mux. With ce=0, q holds across rising edges. Reset still has priority over ce=0, so rst=1 forces q=0 regardless of ce.
  - When undefined: no ce port, and the register loads on every rising edge.

Test Plan:
- Clock period 20 ns. Apply d on falling edges in the sequence 0,1,0,1,1,0,1 with rst=0. After each following rising edge, q equals the d just applied and qb equals its inverse (e.g. d=1 gives q=1, qb=0).
- Glitch immunity: with clk=1, toggle d 0→1→0. q stays at its previous value. Then hold d=1 through the next rising edge and check q=1.
- Synchronous reset: with q=1, raise rst mid-low-phase. q stays 1 until the next rising edge, then q=0 and qb=1. With rst=1 and d=1 at an edge, q remains 0.
- Reset release: drop rst mid-cycle with d=1. q stays 0 until the next rising edge, then q=1.
- WIDTH=8: apply d=8'hA5 then 8'h3C on successive edges. Check q=8'hA5/qb=8'h5A, then q=8'h3C/qb=8'hC3. Each bit must behave independently.
- With DFF_MUX_CE_EN defined: load q=1, then set ce=0 and d=0 for 3 edges and check q stays 1. Set rst=1 with ce=0 and check q=0 after the next edge.
